lc3_mem_initiator: RTL
======================

# lc3_mem_initiator

Bus-initiator sequencer on the CPU side of the LC-3 memory/MMIO interface. It accepts single-word read/write requests from the control FSM, drives address/data/MIO_EN/RW toward the address decoder and memory, waits on the level-ready `R` response, captures read data, and returns a one-cycle completion pulse. It also bounds every access with a timeout, so an unmapped or hung responder cannot stall the datapath.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum number of ACCESS-state cycles to wait for `r` before aborting; valid range 4..255.
- `i_Clk`  in  1  system clock; all logic on rising edge.
- `i_Rst_n`  in  1  synchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  write data.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky timeout flag; cleared when the next request is accepted.
- `rdata`  out  16  registered read data.
- `mar`  out  16  registered address toward the decoder/memory.
- `mdr`  out  16  registered write data toward memory.
- `mio_en`  out  1  access enable toward the decoder.
- `rw`  out  1  1 = write, 0 = read.
- `r`  in  1  responder ready (level).
- `mem_rdata`  in  16  responder read data; valid whenever `r` = 1 on a read.

## Operation
- Reset values: state IDLE; `busy`, `done`, `err`, `mio_en` and `rw` = 0; `mar`, `mdr` and `rdata` = 0x0000; timeout counter = 0.
- IDLE: if `req` = 1, latch `req_addr` into `mar`, `req_wdata` into `mdr` and `req_we` into `rw`; clear `err`; go to SETUP. Otherwise hold.
- SETUP: `mio_en` = 0 for exactly one cycle, so the decoder sees a stable address. Go to ACCESS.
- ACCESS: `mio_en` = 1, counter increments each cycle.
  - `r` = 1 sampled: on a read, `rdata` <= `mem_rdata`. Pulse `done`, drop `mio_en`, clear the counter, go to RELEASE.
  - Counter reaches `TIMEOUT_CYCLES` with `r` = 0: set `err`, pulse `done`, drop `mio_en`, leave `rdata` unchanged, clear the counter, go to RELEASE.
  - If `r` rises on the same edge the counter reaches the limit, `r` wins and the access completes normally with no `err`.
- RELEASE: `mio_en` = 0; wait until `r` = 0, then go to IDLE. If `r` is still high after `TIMEOUT_CYCLES` cycles, go to IDLE anyway and set `err`.
- `mar`, `mdr` and `rw` are held constant from SETUP through RELEASE. Writes never modify `rdata`.
- `req` is ignored while `busy` = 1; no queueing.
- Reset asserted in any state: the next edge applies all reset values. `mio_en` falls immediately and no `done` pulse is produced for the aborted access.

## Timing
- Edges are numbered from the edge that samples `req` in IDLE (edge 0).
- Edge 1: state ACCESS, `mio_en` = 1 (SETUP occupies edge 0 to edge 1).
- RAM responder: `r` rises at edge 2. The initiator samples it at edge 3, then `done` = 1 and `rdata` is valid from edge 3 to edge 4. `r` falls at edge 4, and the block reaches IDLE at edge 5. Minimum throughput is one access per 5 cycles after `req`.
- MMIO responder (3-tick): `done` arrives 2 cycles later than for RAM.
- Timeout: `done` and `err` are high in the cycle after the counter hits `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` + 1 edges after entering ACCESS.
- `busy` rises at edge 0 and falls on the edge entering IDLE. `done` always pulses while `busy` = 1 and never for two consecutive cycles.

## Test plan
- Reset, then read 0x0003 with the responder model returning 0x03FE one cycle after `mio_en` -> `mar` = 0x0003, `rw` = 0, `done` pulse at edge 3, `rdata` = 0x03FE, `err` = 0, IDLE at edge 5.
- Write 0x1234 to 0x0010 -> `mdr` = 0x1234 and `rw` = 1 throughout ACCESS; `done` pulses; `rdata` keeps its previous value.
- MMIO read of 0xFF01 with the responder asserting `r` after 3 cycles -> `done` 2 cycles later than the RAM case, `rdata` = model value.
- Responder never asserts `r`, `TIMEOUT_CYCLES` = 15 -> `mio_en` drops and `done` and `err` go high 16 edges after ACCESS entry; the next accepted `req` clears `err`.
- `req` held high continuously, plus a second `req` pulsed while `busy` -> exactly one access per IDLE visit and the mid-access request is dropped; `r` held high after `done` -> block stays in RELEASE until `r` falls.
- `i_Rst_n` = 0 during ACCESS -> next edge gives `mio_en` = 0, `busy` = 0, `mar` = 0x0000, no `done` pulse.

Source files
------------

// File: rtl/lc3_mem_initiator.sv
// CPU-side bus initiator for the LC-3 memory/MMIO path: one word per request,
// level-ready handshake on r, bounded wait so a silent responder cannot hang the core.
module lc3_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] mar,
    output logic [15:0] mdr,
    output logic        mio_en,
    output logic        rw,
    input  logic        r,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RELEASE
    } state_t;

    localparam logic [7:0] ACC_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] REL_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        mio_en_reg, mio_en_next;
    logic        rw_reg, rw_next;
    logic [15:0] rdata_reg, rdata_next;
    logic [15:0] mar_reg, mar_next;
    logic [15:0] mdr_reg, mdr_next;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 8'd0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            mio_en_reg <= 1'b0;
            rw_reg     <= 1'b0;
            rdata_reg  <= 16'h0000;
            mar_reg    <= 16'h0000;
            mdr_reg    <= 16'h0000;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            mio_en_reg <= mio_en_next;
            rw_reg     <= rw_next;
            rdata_reg  <= rdata_next;
            mar_reg    <= mar_next;
            mdr_reg    <= mdr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        mio_en_next = 1'b0;
        rw_next     = rw_reg;
        rdata_next  = rdata_reg;
        mar_next    = mar_reg;
        mdr_next    = mdr_reg;

        case (state_reg)
            S_IDLE: begin
                cnt_next = 8'd0;
                if (req) begin
                    mar_next   = req_addr;
                    mdr_next   = req_wdata;
                    rw_next    = req_we;
                    err_next   = 1'b0;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                // Address settles one cycle before the decoder is enabled.
                mio_en_next = 1'b1;
                state_next  = S_ACCESS;
            end
            S_ACCESS: begin
                if (r) begin
                    if (!rw_reg) begin
                        rdata_next = mem_rdata;
                    end
                    done_next  = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = S_RELEASE;
                end else if (cnt_reg == ACC_LIMIT) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = S_RELEASE;
                end else begin
                    cnt_next    = cnt_reg + 8'd1;
                    mio_en_next = 1'b1;
                end
            end
            S_RELEASE: begin
                // Responder must drop r before the next access may start.
                if (!r) begin
                    cnt_next   = 8'd0;
                    state_next = S_IDLE;
                end else if (cnt_reg == REL_LIMIT) begin
                    err_next   = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign err    = err_reg;
    assign mio_en = mio_en_reg;
    assign rw     = rw_reg;
    assign rdata  = rdata_reg;
    assign mar    = mar_reg;
    assign mdr    = mdr_reg;

endmodule
